// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//   Bundles the fetch-side lookup, the execute-side resolve/train request and
//   the status outputs of branch_predictor into one interface.
//
//   Signal groups:
//     fetch   : fetch_pc -> predict_taken, predict_target
//     resolve : ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken,
//               ex_pred_target -> branch_miss, correct_pc
//     status  : ready, lookup_cnt, miss_cnt, dbg_state
//
//   Handshake: ex_branch is a single-cycle valid qualifier for the ex_* fields.
//   There is no ready/backpressure; a resolved branch presented while the
//   predictor reports ready=1 is always consumed on that clock edge, and one
//   presented while ready=0 is ignored. fetch_pc is looked up every cycle
//   without a qualifier.
//
//   Modports: master = pipeline side (drives fetch/resolve inputs),
//             slave  = predictor side.
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             predict_taken;
    logic [PC_W-1:0]  predict_target;

    logic             ex_branch;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_pred_target;
    logic             branch_miss;
    logic [PC_W-1:0]  correct_pc;

    logic             ready;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic             dbg_state;   // 0 = INIT sweep, 1 = RUN

    modport master (
        output fetch_pc, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  predict_taken, predict_target, branch_miss, correct_pc,
               ready, lookup_cnt, miss_cnt, dbg_state
    );

    modport slave (
        input  fetch_pc, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output predict_taken, predict_target, branch_miss, correct_pc,
               ready, lookup_cnt, miss_cnt, dbg_state
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Fetch looks up the table combinationally; execute resolves the
//   carried prediction against the real outcome, flags a miss with the
//   corrected PC, and trains the table on the following edge.
//
//   Ports:
//     clk    : clock
//     reset  : synchronous, active-high; restarts the table-clearing sweep
//     bus    : branch_predictor_if.slave (fetch lookup, EX resolve, status)
//
//   After reset the table is cleared one entry per cycle (INIT); ready rises
//   once every entry has been written, and only then are predictions, misses,
//   training and statistics enabled (RUN).
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bus
);
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int ENTRIES = 2 ** IDX_W;

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [1:0]       cnt;
    } entry_t;

    // Table storage has no reset; the INIT sweep is what clears it.
    entry_t tbl [ENTRIES];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic run;
    assign run = (state_q == S_RUN) && !reset;

    // ---------------- fetch lookup ----------------
    logic [IDX_W-1:0] f_idx;
    entry_t           f_entry;
    logic             f_hit;
    logic             predict_taken;

    assign f_idx         = bus.fetch_pc[IDX_W-1:0];
    assign f_entry       = tbl[f_idx];
    assign f_hit         = f_entry.valid && (f_entry.tag == bus.fetch_pc[PC_W-1:IDX_W]);
    assign predict_taken = run && f_hit && f_entry.cnt[1];

    assign bus.predict_taken  = predict_taken;
    assign bus.predict_target = predict_taken ? f_entry.target : '0;

    // ---------------- EX resolve ----------------
    logic            dir_wrong, tgt_wrong, branch_miss;
    logic [PC_W-1:0] seq_pc;

    assign dir_wrong   = bus.ex_taken != bus.ex_pred_taken;
    // Both said taken but to different places: still a redirect.
    assign tgt_wrong   = bus.ex_taken && bus.ex_pred_taken &&
                         (bus.ex_target != bus.ex_pred_target);
    assign branch_miss = run && bus.ex_branch && (dir_wrong || tgt_wrong);
    assign seq_pc      = bus.ex_pc + PC_W'(1);   // wraps at the top of imem

    assign bus.branch_miss = branch_miss;
    assign bus.correct_pc  = !branch_miss ? '0 :
                             (bus.ex_taken ? bus.ex_target : seq_pc);

    // ---------------- table write port ----------------
    logic [IDX_W-1:0] e_idx;
    entry_t           e_entry;
    logic             e_hit;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    entry_t           wr_entry;

    assign e_idx   = bus.ex_pc[IDX_W-1:0];
    assign e_entry = tbl[e_idx];
    assign e_hit   = e_entry.valid && (e_entry.tag == bus.ex_pc[PC_W-1:IDX_W]);

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = e_idx;
        wr_entry = e_entry;
        if (state_q == S_INIT) begin
            wr_en           = 1'b1;
            wr_idx          = ptr_q;
            wr_entry.valid  = 1'b0;
            wr_entry.tag    = '0;
            wr_entry.target = '0;
            wr_entry.cnt    = 2'b01;   // weakly not-taken
        end else if (run && bus.ex_branch) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (bus.ex_taken) begin
                    wr_entry.target = bus.ex_target;
                    if (e_entry.cnt != 2'b11) wr_entry.cnt = e_entry.cnt + 2'b01;
                end else if (e_entry.cnt != 2'b00) begin
                    wr_entry.cnt = e_entry.cnt - 2'b01;
                end
            end else if (bus.ex_taken) begin
                // Allocate (or evict an alias) as weakly taken.
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = bus.ex_pc[PC_W-1:IDX_W];
                wr_entry.target = bus.ex_target;
                wr_entry.cnt    = 2'b10;
            end
        end
    end

    // Written on the edge, so a same-cycle lookup sees pre-update contents.
    always_ff @(posedge clk) begin
        if (wr_en) tbl[wr_idx] <= wr_entry;
    end

    // ---------------- control / statistics ----------------
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lookup_cnt_d = lookup_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (reset) begin
            state_d      = S_INIT;
            ptr_d        = '0;
            lookup_cnt_d = '0;
            miss_cnt_d   = '0;
        end else if (state_q == S_INIT) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == '1) state_d = S_RUN;
        end else begin
            if (bus.ex_branch && (lookup_cnt_q != '1)) lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
            if (branch_miss && (miss_cnt_q != '1))     miss_cnt_d   = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        ptr_q        <= ptr_d;
        lookup_cnt_q <= lookup_cnt_d;
        miss_cnt_q   <= miss_cnt_d;
    end

    assign bus.ready      = (state_q == S_RUN);
    assign bus.dbg_state  = state_q;
    assign bus.lookup_cnt = lookup_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed scenarios followed by random traffic, every cycle compared
//   against a behavioural table model of the predictor.
// -----------------------------------------------------------------------------
module tb_branch_predictor;
  localparam int PC_W    = 10;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 16;
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PC_MOD  = 2 ** PC_W;
  localparam int SAT     = 2 ** CNT_W - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  bit m_valid  [ENTRIES];
  int m_tag    [ENTRIES];
  int m_target [ENTRIES];
  int m_cnt    [ENTRIES];
  int m_sweep;          // edges since reset released, capped at ENTRIES
  bit m_known = 1'b0;   // DUT state defined once a reset edge has been seen
  int m_lookups, m_misses;

  int pool [8] = '{32'h045, 32'h065, 32'h3FF, 32'h01F, 32'h100, 32'h120, 32'h000, 32'h2A5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, advance the model across the
  // coming posedge, and return at the following negedge.
  task automatic finish_cycle();
    int  fi, ft, ei, et, ptgt, cpc, fpc, epc, etg, eptg;
    bit  rdy, run, pt, hit, miss;
    fpc  = int'(bus.fetch_pc);
    epc  = int'(bus.ex_pc);
    etg  = int'(bus.ex_target);
    eptg = int'(bus.ex_pred_target);
    rdy  = (m_sweep >= ENTRIES);
    run  = rdy && !reset;
    fi   = fpc % ENTRIES;
    ft   = fpc / ENTRIES;
    pt   = run && m_valid[fi] && (m_tag[fi] == ft) && (m_cnt[fi] >= 2);
    ptgt = pt ? m_target[fi] : 0;
    miss = run && bus.ex_branch &&
           ((bus.ex_taken != bus.ex_pred_taken) ||
            (bus.ex_taken && bus.ex_pred_taken && (etg != eptg)));
    cpc  = !miss ? 0 : (bus.ex_taken ? etg : (epc + 1) % PC_MOD);
    if (m_known) begin
      check("ready",          32'(bus.ready),          32'(rdy));
      check("dbg_state",      32'(bus.dbg_state),      32'(rdy));
      check("predict_taken",  32'(bus.predict_taken),  32'(pt));
      check("predict_target", 32'(bus.predict_target), 32'(ptgt));
      check("branch_miss",    32'(bus.branch_miss),    32'(miss));
      check("correct_pc",     32'(bus.correct_pc),     32'(cpc));
      check("lookup_cnt",     32'(bus.lookup_cnt),     32'(m_lookups));
      check("miss_cnt",       32'(bus.miss_cnt),       32'(m_misses));
    end
    if (reset) begin
      m_known   = 1'b1;
      m_sweep   = 0;
      m_lookups = 0;
      m_misses  = 0;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
    end else if (m_known) begin
      if (!rdy) begin
        m_sweep++;
      end else if (bus.ex_branch) begin
        ei  = epc % ENTRIES;
        et  = epc / ENTRIES;
        hit = m_valid[ei] && (m_tag[ei] == et);
        if (hit) begin
          if (bus.ex_taken) begin
            m_target[ei] = etg;
            if (m_cnt[ei] < 3) m_cnt[ei]++;
          end else if (m_cnt[ei] > 0) begin
            m_cnt[ei]--;
          end
        end else if (bus.ex_taken) begin
          m_valid[ei]  = 1'b1;
          m_tag[ei]    = et;
          m_target[ei] = etg;
          m_cnt[ei]    = 2;
        end
        if (m_lookups < SAT) m_lookups++;
        if (miss && m_misses < SAT) m_misses++;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    finish_cycle();
  endtask

  // ---------------- driver ----------------
  task automatic set_ex(input bit b, input int pc, input bit tk, input int tg,
                        input bit ptk, input int ptg);
    bus.ex_branch      = b;
    bus.ex_pc          = PC_W'(pc);
    bus.ex_taken       = tk;
    bus.ex_target      = PC_W'(tg);
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = PC_W'(ptg);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    bus.fetch_pc = '0;
    set_ex(0, 0, 0, 0, 0, 0);
    finish_cycle();                  // first reset edge; state not yet known
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    finish_cycle();
    reset = 1'b0;

    // Sweep: ready exactly after ENTRIES edges, no prediction meanwhile.
    for (int k = 0; k <= ENTRIES; k++) begin
      bus.fetch_pc = PC_W'($urandom_range(0, PC_MOD - 1));
      #1;
      check("sweep_ready", 32'(bus.ready), 32'(k >= ENTRIES));
      if (k < ENTRIES) check("sweep_predict", 32'(bus.predict_taken), 32'd0);
      finish_cycle();
    end

    // Taken branch, predicted not-taken: redirect to target and allocate.
    bus.fetch_pc = PC_W'(12'h045);
    set_ex(1, 'h045, 1, 'h120, 0, 0);
    #1;
    check("t2_miss", 32'(bus.branch_miss), 32'd1);
    check("t2_cpc", 32'(bus.correct_pc), 32'h120);
    check("t2_same_cycle_no_bypass", 32'(bus.predict_taken), 32'd0);
    finish_cycle();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    check("t2_predict", 32'(bus.predict_taken), 32'd1);
    check("t2_target", 32'(bus.predict_target), 32'h120);
    finish_cycle();

    // Two not-taken resolutions: 10 -> 01 -> 00.
    set_ex(1, 'h045, 0, 0, 1, 'h120);
    #1;
    check("t3_miss1", 32'(bus.branch_miss), 32'd1);
    check("t3_cpc1", 32'(bus.correct_pc), 32'h046);
    finish_cycle();
    #1;
    check("t3_weak_nt", 32'(bus.predict_taken), 32'd0);
    check("t3_miss2", 32'(bus.branch_miss), 32'd1);
    check("t3_cpc2", 32'(bus.correct_pc), 32'h046);
    finish_cycle();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    check("t3_after", 32'(bus.predict_taken), 32'd0);
    finish_cycle();

    // Retrain 0x045 to 10, then alias 0x065 onto the same index.
    set_ex(1, 'h045, 1, 'h120, 0, 0);
    step();
    step();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    check("t4_045_taken", 32'(bus.predict_taken), 32'd1);
    finish_cycle();
    bus.fetch_pc = PC_W'(12'h065);
    #1;
    check("t4_alias_no_hit", 32'(bus.predict_taken), 32'd0);
    finish_cycle();
    set_ex(1, 'h065, 1, 'h200, 0, 0);
    #1;
    check("t4_alias_miss", 32'(bus.branch_miss), 32'd1);
    finish_cycle();
    set_ex(0, 0, 0, 0, 0, 0);
    bus.fetch_pc = PC_W'(12'h045);
    #1;
    check("t4_045_evicted", 32'(bus.predict_taken), 32'd0);
    finish_cycle();
    bus.fetch_pc = PC_W'(12'h065);
    #1;
    check("t4_065_taken", 32'(bus.predict_taken), 32'd1);
    check("t4_065_target", 32'(bus.predict_target), 32'h200);
    finish_cycle();

    // PC wrap and wrong-target cases.
    set_ex(1, 'h3FF, 0, 0, 1, 'h050);
    #1;
    check("t5_wrap_miss", 32'(bus.branch_miss), 32'd1);
    check("t5_wrap_cpc", 32'(bus.correct_pc), 32'h000);
    finish_cycle();
    set_ex(1, 'h100, 1, 'h020, 1, 'h010);
    #1;
    check("t5_tgt_miss", 32'(bus.branch_miss), 32'd1);
    check("t5_tgt_cpc", 32'(bus.correct_pc), 32'h020);
    finish_cycle();
    set_ex(1, 'h100, 1, 'h020, 1, 'h020);
    #1;
    check("t5_correct_no_miss", 32'(bus.branch_miss), 32'd0);
    check("t5_correct_cpc0", 32'(bus.correct_pc), 32'd0);
    finish_cycle();
    set_ex(0, 'h100, 1, 'h020, 0, 0);
    #1;
    check("t5_no_branch", 32'(bus.branch_miss), 32'd0);
    finish_cycle();

    // Random traffic over a small aliasing PC pool.
    for (int n = 0; n < 400; n++) begin
      bus.fetch_pc = PC_W'(pool[$urandom_range(0, 7)]);
      set_ex($urandom_range(0, 1), pool[$urandom_range(0, 7)], $urandom_range(0, 1),
             pool[$urandom_range(0, 7)], $urandom_range(0, 1), pool[$urandom_range(0, 7)]);
      step();
    end

    // Reset at sweep cycle 10 restarts the full sweep.
    set_ex(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.fetch_pc = PC_W'(12'h065);
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k <= ENTRIES; k++) begin
      bus.fetch_pc = PC_W'(pool[$urandom_range(0, 7)]);
      #1;
      check("t6_ready", 32'(bus.ready), 32'(k >= ENTRIES));
      check("t6_lookup_zero", 32'(bus.lookup_cnt), 32'd0);
      finish_cycle();
    end

    // Saturate both statistics counters.
    set_ex(1, 'h045, 1, 'h120, 0, 0);
    for (int n = 0; n < SAT + 6; n++) step();
    set_ex(0, 0, 0, 0, 0, 0);
    #1;
    check("t6_miss_sat", 32'(bus.miss_cnt), 32'h0000FFFF);
    check("t6_lookup_sat", 32'(bus.lookup_cnt), 32'h0000FFFF);
    finish_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
